wbledpwm_fade: RTL and testbench
================================

# wbledpwm_fade

Parametrised Wishbone (pipelined) LED PWM controller with NCH independent channels, programmable PWM resolution, a clock prescaler and per-channel hardware fading toward a target duty. Sits as a crossbar slave beside the boot ROM and SRAM, drives board LEDs directly, and is the successor to the fixed-function LED PWM peripheral.

## Interface
- AW, 30, word-address width of wb_adr_i
- DW, 32, data width; must be 32
- NCH, 4, channel count, 1..8
- PW, 8, PWM resolution bits, 4..16
- PSW, 16, prescaler register width, 1..32

Ports:
- wb_clk_i  in  1  system clock
- wb_reset_ni  in  1  reset, asynchronous assert, active-low
- wb_adr_i  in  AW  word address; only bits [4:0] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid only with wb_ack_o
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte lane enables for writes
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge
- wb_stall_o  out  1  tied 0
- leds  out  NCH  LED drive, one per channel

## Operation
- Register map (index = wb_adr_i[4:0]); unmapped reads return 0, unmapped writes ignored; undefined bits read 0:
  - 0x00 CTRL: bit0 EN, bit1 INV.
  - 0x01 PRESCALE: [PSW-1:0].
  - 0x10+n CHn (n<NCH): [PW-1:0] target duty, [23:16] step. Write-only fields of each byte written only when the matching wb_sel_i bit is set.
  - 0x18+n CURn (n<NCH): read-only, [PW-1:0] current duty.
- Prescaler: pre_cnt increments each clock; when pre_cnt >= PRESCALE, tick=1 and pre_cnt<=0. PRESCALE=0 gives tick every clock.
- PWM counter cnt (PW bits) increments on tick, wraps 2^PW-1 -> 0. wrap = tick && cnt==all-ones.
- Channel output raw_n = (cnt < cur_n). Duty 0 is always off; all-ones is on (2^PW-1)/2^PW. No full-on state.
- Fading, per channel:
  - step==0: cur_n <= target_n on the next clock, independent of wrap.
  - step!=0: on each wrap, cur_n moves toward target_n by step. Compute in PW+1 bits; if |target-cur| <= step, cur <= target (no overshoot, no wrap-around).
  - A target write mid-fade takes effect at the next wrap.
- EN=0: pre_cnt, cnt held at 0; cur_n still updates for step==0 only; leds = {NCH{INV}}.
- EN=1: leds_n = raw_n ^ INV.
- Wishbone: every cycle with wb_cyc_i&&wb_stb_i is a request, accepted immediately (no stall). Writes commit at that edge; a register write and an internal fade update to the same cur_n are never in conflict because cur_n is not writable.

## Timing
- Reset (wb_reset_ni low, async): all registers 0, cur_n 0, pre_cnt/cnt 0, wb_ack_o 0, wb_dat_o 0, leds 0. Outputs reach reset values without a clock edge; release is synchronous.
- wb_ack_o registered: ack = cyc&&stb of the previous cycle, AND current wb_cyc_i. Dropping cyc suppresses pending acks. Back-to-back requests give back-to-back acks, one per request.
- wb_dat_o registered with ack; 0 when ack is low.
- Write-to-effect: CTRL/PRESCALE/target visible to logic the cycle after the accepting edge. Readback of a just-written register on the next request returns the new value.
- leds registered: reflects cnt/cur of the previous cycle (1-clock latency).
- PWM period = 2^PW*(PRESCALE+1) clocks.

## Test plan
- Reset: drive wb_reset_ni low mid-fade with no clock edge -> leds=0, wb_ack_o=0 immediately; after release, reads of 0x00/0x01/0x10/0x18 return 0.
- Static PWM (PW=8): CTRL=1, PRESCALE=0, CH0=0x00000040 -> leds[0] high exactly 64 of every 256 clocks; CH1=0 -> never high; CH2=0xFF -> 255 of 256. CTRL=3 -> leds inverted; CTRL=2 -> leds all 1.
- Prescale: PRESCALE=3, CH0=0x80 -> period 1024 clocks, high 512.
- Fade: CH2=0x00030010 from cur 0 -> CUR2 reads 3,6,9,12,15,16 after successive wraps, then holds; then CH2=0x00050000 -> 11,6,1,0.
- Byte lanes: CH0=0, write 0x00050080 with sel=0001 -> CH0 reads 0x00000080; sel=0100 -> 0x00050080.
- Bus: 3 consecutive strobes -> 3 consecutive acks, stall 0; drop cyc after first strobe -> only one ack; read of 0x07 -> 0.

Source files
------------

// File: rtl/wbledpwm_fade.sv
// Wishbone LED PWM with prescaler and per-channel fading toward a target duty.
// Single-cycle registered ack, never stalls; leds lag the PWM state by one clock.
module wbledpwm_fade #(
  parameter int AW  = 30,
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int PW  = 8,
  parameter int PSW = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_reset_ni,
  input  logic [AW-1:0]  wb_adr_i,
  input  logic [DW-1:0]  wb_dat_i,
  output logic [DW-1:0]  wb_dat_o,
  input  logic           wb_we_i,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  output logic           wb_ack_o,
  output logic           wb_stall_o,
  output logic [NCH-1:0] leds
);

  localparam int CW = ((PW > 8) ? PW : 8) + 1;

  logic           req, wr;
  logic [4:0]     idx;
  logic           en, inv;
  logic [PSW-1:0] prescale, pre_cnt;
  logic [PW-1:0]  cnt;
  logic [PW-1:0]  target   [NCH];
  logic [7:0]     step     [NCH];
  logic [PW-1:0]  cur      [NCH];
  logic [PW-1:0]  cur_next [NCH];
  logic [NCH-1:0] raw;
  logic           tick, wrap;
  logic           req_q;
  logic [DW-1:0]  dat_q, rd_data;
  logic [31:0]    bmask, ch_old, ctrl_new, pre_new, ch_new;
  logic           unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign req = wb_cyc_i && wb_stb_i;
  assign wr  = req && wb_we_i;
  assign idx = wb_adr_i[4:0];

  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  // Byte-lane writes: merge the new data into the current register image.
  always_comb begin
    ch_old = '0;
    for (int n = 0; n < NCH; n++) begin
      if (idx[2:0] == 3'(n)) ch_old = {8'h00, step[n], 16'(target[n])};
    end
  end

  assign ctrl_new = merge({30'h0, inv, en}, wb_dat_i, bmask);
  assign pre_new  = merge(32'(prescale), wb_dat_i, bmask);
  assign ch_new   = merge(ch_old, wb_dat_i, bmask);

  assign unused_bits = ^{wb_adr_i[AW-1:5], ctrl_new[31:2], pre_new, ch_new[31:24], ch_new[15:0]};

  assign tick = en && (pre_cnt >= prescale);
  assign wrap = tick && (cnt == '1);

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (!en) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PSW'(1);
      if (tick) cnt <= cnt + PW'(1);
    end
  end

  // Step never exceeds the remaining distance when added, so PW'(step) is exact.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      cur_next[n] = cur[n];
      if (step[n] == 8'h00) begin
        cur_next[n] = target[n];
      end else if (wrap) begin
        if (target[n] > cur[n]) begin
          if ((CW'(target[n]) - CW'(cur[n])) <= CW'(step[n])) cur_next[n] = target[n];
          else cur_next[n] = cur[n] + PW'(step[n]);
        end else if (target[n] < cur[n]) begin
          if ((CW'(cur[n]) - CW'(target[n])) <= CW'(step[n])) cur_next[n] = target[n];
          else cur_next[n] = cur[n] - PW'(step[n]);
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) raw[n] = (cnt < cur[n]);
  end

  always_comb begin
    rd_data = '0;
    if (idx == 5'h00) rd_data = {30'h0, inv, en};
    if (idx == 5'h01) rd_data = DW'(prescale);
    for (int n = 0; n < NCH; n++) begin
      if (idx == 5'(16 + n)) rd_data = {8'h00, step[n], 16'(target[n])};
      if (idx == 5'(24 + n)) rd_data = DW'(cur[n]);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      req_q    <= 1'b0;
      dat_q    <= '0;
      leds     <= '0;
      en       <= 1'b0;
      inv      <= 1'b0;
      prescale <= '0;
      for (int n = 0; n < NCH; n++) begin
        target[n] <= '0;
        step[n]   <= '0;
        cur[n]    <= '0;
      end
    end else begin
      req_q <= req;
      dat_q <= (req && !wb_we_i) ? rd_data : '0;
      leds  <= en ? (raw ^ {NCH{inv}}) : {NCH{inv}};
      if (wr && idx == 5'h00) begin
        en  <= ctrl_new[0];
        inv <= ctrl_new[1];
      end
      if (wr && idx == 5'h01) prescale <= pre_new[PSW-1:0];
      for (int n = 0; n < NCH; n++) begin
        if (wr && idx == 5'(16 + n)) begin
          target[n] <= ch_new[PW-1:0];
          step[n]   <= ch_new[23:16];
        end
        cur[n] <= cur_next[n];
      end
    end
  end

  // Dropping cyc cancels an ack still owed for the previous request.
  assign wb_ack_o   = req_q && wb_cyc_i;
  assign wb_dat_o   = wb_ack_o ? dat_q : '0;
  assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wbledpwm_fade.sv
// Directed bench for wbledpwm_fade: register table, PWM duty/period, fading, bus handshake, reset.
module tb_wbledpwm_fade;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic        stall;
  logic [3:0]  leds;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wbledpwm_fade dut (
    .wb_clk_i(clk), .wb_reset_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc),
    .wb_stb_i(stb), .wb_ack_o(ack), .wb_stall_o(stall), .leds(leds)
  );

  typedef struct {
    logic [4:0]  wadr;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic [4:0]  radr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {25'b0, a}; dat_i = d; sel = s;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check("ack", {31'b0, ack}, 32'd1);
    r = dat_o;
    cyc = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(a, 1'b1, d, s, dummy);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] r);
    bus(a, 1'b0, 32'h0, 4'h0, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_high(input int cycles, output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    repeat (cycles) begin
      @(negedge clk);
      c0 += int'(leds[0]); c1 += int'(leds[1]); c2 += int'(leds[2]); c3 += int'(leds[3]);
    end
  endtask

  task automatic wait_change(input logic [4:0] a, input logic [31:0] prev, output logic [31:0] v);
    v = prev;
    for (int k = 0; k < 400 && v == prev; k++) rd(a, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int c0, c1, c2, c3;
    int cyc_cnt;
    logic prev_led;
    logic [4:0] pat;
    logic stall_seen;
    int fade_up[6];
    int fade_dn[4];

    vecs[0]  = '{5'h00, 32'hFFFF_FFFF, 4'hF, 5'h00, 32'h0000_0003};
    vecs[1]  = '{5'h00, 32'h0000_0000, 4'h0, 5'h00, 32'h0000_0003};
    vecs[2]  = '{5'h00, 32'h0000_0000, 4'h1, 5'h00, 32'h0000_0000};
    vecs[3]  = '{5'h01, 32'h0001_2345, 4'hF, 5'h01, 32'h0000_2345};
    vecs[4]  = '{5'h01, 32'h0000_FFFF, 4'h2, 5'h01, 32'h0000_FF45};
    vecs[5]  = '{5'h10, 32'hFFFF_FFFF, 4'hF, 5'h10, 32'h00FF_00FF};
    vecs[6]  = '{5'h13, 32'h0000_1234, 4'h1, 5'h13, 32'h0000_0034};
    vecs[7]  = '{5'h11, 32'h0000_AB00, 4'h2, 5'h11, 32'h0000_0000};
    vecs[8]  = '{5'h07, 32'hFFFF_FFFF, 4'hF, 5'h07, 32'h0000_0000};
    vecs[9]  = '{5'h18, 32'hFFFF_FFFF, 4'hF, 5'h18, 32'h0000_0000};
    vecs[10] = '{5'h1B, 32'h0000_0000, 4'hF, 5'h1B, 32'h0000_0034};
    vecs[11] = '{5'h10, 32'h0000_0000, 4'hF, 5'h10, 32'h0000_0000};
    vecs[12] = '{5'h10, 32'h0005_0080, 4'h1, 5'h10, 32'h0000_0080};
    vecs[13] = '{5'h10, 32'h0005_0080, 4'h4, 5'h10, 32'h0005_0080};
    vecs[14] = '{5'h14, 32'hFFFF_FFFF, 4'hF, 5'h14, 32'h0000_0000};
    vecs[15] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 5'h1C, 32'h0000_0000};
    fade_up = '{3, 6, 9, 12, 15, 16};
    fade_dn = '{11, 6, 1, 0};

    // Power-on reset
    #12;
    check("rst_leds", {28'b0, leds}, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register table
    for (int i = 0; i < 16; i++) begin
      wr(vecs[i].wadr, vecs[i].wdat, vecs[i].wsel);
      rd(vecs[i].radr, r);
      check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Static PWM
    do_reset();
    wr(5'h10, 32'h0000_0040, 4'hF);
    wr(5'h11, 32'h0000_0000, 4'hF);
    wr(5'h12, 32'h0000_00FF, 4'hF);
    wr(5'h00, 32'h1, 4'hF);
    count_high(256, c0, c1, c2, c3);
    check("pwm_ch0", c0, 64);
    check("pwm_ch1", c1, 0);
    check("pwm_ch2", c2, 255);
    check("pwm_ch3", c3, 0);
    wr(5'h00, 32'h3, 4'hF);
    repeat (2) @(negedge clk);
    count_high(256, c0, c1, c2, c3);
    check("inv_ch0", c0, 192);
    check("inv_ch1", c1, 256);
    check("inv_ch2", c2, 1);
    wr(5'h00, 32'h2, 4'hF);
    repeat (2) @(negedge clk);
    cyc_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (leds == 4'hF) cyc_cnt++;
    end
    check("dis_inv_all_on", cyc_cnt, 20);

    // Prescaler
    do_reset();
    wr(5'h01, 32'h3, 4'hF);
    wr(5'h10, 32'h80, 4'hF);
    wr(5'h00, 32'h1, 4'hF);
    prev_led = leds[0];
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (leds[0] && !prev_led) break;
      prev_led = leds[0];
    end
    prev_led = 1'b1;
    cyc_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cyc_cnt++;
      if (leds[0] && !prev_led) break;
      prev_led = leds[0];
    end
    check("pre_period", cyc_cnt, 1024);
    count_high(1024, c0, c1, c2, c3);
    check("pre_high", c0, 512);

    // Fading
    do_reset();
    wr(5'h12, 32'h0003_0010, 4'hF);
    wr(5'h00, 32'h1, 4'hF);
    r = 32'h0;
    for (int i = 0; i < 6; i++) begin
      wait_change(5'h1A, r, r);
      check($sformatf("fade_up%0d", i), r, fade_up[i]);
    end
    repeat (300) @(negedge clk);
    rd(5'h1A, r);
    check("fade_hold", r, 32'd16);
    wr(5'h12, 32'h0005_0000, 4'hF);
    rd(5'h1A, r);
    check("fade_wait_wrap", r, 32'd16);
    for (int i = 0; i < 4; i++) begin
      wait_change(5'h1A, r, r);
      check($sformatf("fade_dn%0d", i), r, fade_dn[i]);
    end

    // Back-to-back requests
    do_reset();
    pat = '0;
    stall_seen = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat[i] = ack;
      stall_seen |= stall;
      if (i == 2) stb = 1'b0;
    end
    cyc = 1'b0;
    check("b2b_acks", {27'b0, pat}, 32'b00111);
    check("stall", {31'b0, stall_seen}, 32'h0);

    // Dropping cyc cancels the owed ack
    pat = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cyc = 1'b0; stb = 1'b0;
        #1;
      end
      pat[i] = ack;
    end
    check("drop_cyc_acks", {28'b0, pat[3:0]}, 32'b0001);
    check("idle_dat", dat_o, 32'h0);

    // Asynchronous reset mid-fade
    do_reset();
    wr(5'h10, 32'h0001_0080, 4'hF);
    wr(5'h11, 32'h0000_00FF, 4'hF);
    wr(5'h00, 32'h1, 4'hF);
    repeat (300) @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
    @(posedge clk);
    #2;
    check("pre_rst_ack", {31'b0, ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_leds", {28'b0, leds}, 32'h0);
    check("async_ack", {31'b0, ack}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'h00, r); check("rst_ctrl", r, 32'h0);
    rd(5'h01, r); check("rst_pre", r, 32'h0);
    rd(5'h10, r); check("rst_ch0", r, 32'h0);
    rd(5'h18, r); check("rst_cur0", r, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
